uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 24 ++
 rtl/uart_tx_sched_tx_fifo.sv | 52 +++++
 rtl/uart_tx_sched.sv | 108 ++++++++++
 tb/tb_uart_tx_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared Pacoblaze I/O map (bamse address macros) and UART TX scheduler types.
`ifndef BAMSE_IO_DEFS
`define BAMSE_IO_DEFS
`define BAMSE_ADDR_UART_TX_DATA 8'h10
`define BAMSE_ADDR_UART_TX_CTRL 8'h11
`define BAMSE_ADDR_UART_TX_STAT 8'h12
`define BAMSE_UART_STAT_EMPTY 0
`define BAMSE_UART_STAT_FULL 1
`define BAMSE_UART_STAT_BUSY 2
`define BAMSE_UART_STAT_OVF 3
`define BAMSE_UART_CTRL_EN 0
`define BAMSE_UART_CTRL_FLUSH 1
`endif

package uart_tx_sched_pkg;

   typedef enum logic [1:0] {StIdle, StSend, StWait, StGap} tx_state_e;

   // Status nibble can only show 0..15; a 16-deep FIFO that is full reads as 15.
   function automatic logic [3:0] sat_count4(input int unsigned c);
      return (c > 15) ? 4'd15 : 4'(c);
   endfunction

endpackage

// File: rtl/uart_tx_sched_tx_fifo.sv
// Byte FIFO for the UART TX scheduler: power-of-two depth, wrapping pointers, sync flush.
module uart_tx_sched_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [7:0]    din,
   output logic [7:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;

   // Callers never push when full without a pop, nor pop when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_q] <= din;
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// Pacoblaze-mapped UART TX scheduler: queues bytes and hands them one at a time to a transmitter.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter logic [7:0]  ADDR_DATA = `BAMSE_ADDR_UART_TX_DATA,
   parameter logic [7:0]  ADDR_CTRL = `BAMSE_ADDR_UART_TX_CTRL,
   parameter logic [7:0]  ADDR_STAT = `BAMSE_ADDR_UART_TX_STAT,
   parameter int unsigned DEPTH     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] port_id,
   input  logic [7:0] port_in,
   input  logic       wen,
   input  logic       ren,
   output logic [7:0] port_out,
   output logic       tx_dv,
   output logic [7:0] tx_byte,
   input  logic       tx_done,
   output logic       int_tx_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   tx_state_e   state_q, state_d;
   logic        en_q, ovf_q;
   logic [7:0]  tx_byte_q;
   logic [7:0]  status;

   logic        wr_data, wr_ctrl, flush, push, pop, ovf_set;
   logic [7:0]  fifo_head;
   logic [AW:0] fifo_count;
   logic        fifo_full, fifo_empty;

   assign wr_data = wen && (port_id == ADDR_DATA);
   assign wr_ctrl = wen && (port_id == ADDR_CTRL);
   assign flush   = wr_ctrl && port_in[`BAMSE_UART_CTRL_FLUSH];
   // A full FIFO still takes a byte when the scheduler pops in the same cycle.
   assign push    = wr_data && !flush && (!fifo_full || pop);
   assign ovf_set = wr_data && !flush && fifo_full && !pop;

   uart_tx_sched_tx_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (port_in),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      tx_dv   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (en_q && !fifo_empty) begin
               pop     = 1'b1;
               state_d = StSend;
            end
         end
         StSend: begin
            tx_dv   = 1'b1;
            state_d = StWait;
         end
         StWait:  if (tx_done) state_d = StGap;
         StGap:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         en_q      <= 1'b0;
         ovf_q     <= 1'b0;
         tx_byte_q <= 8'h00;
      end else begin
         state_q <= state_d;
         if (wr_ctrl) en_q <= port_in[`BAMSE_UART_CTRL_EN];
         // New overflow takes priority over a status-read clear.
         if (ovf_set) ovf_q <= 1'b1;
         else if (ren && (port_id == ADDR_STAT)) ovf_q <= 1'b0;
         if (pop) tx_byte_q <= fifo_head;
      end
   end

   always_comb begin
      status                        = 8'h00;
      status[`BAMSE_UART_STAT_EMPTY] = fifo_empty;
      status[`BAMSE_UART_STAT_FULL]  = fifo_full;
      status[`BAMSE_UART_STAT_BUSY]  = (state_q != StIdle);
      status[`BAMSE_UART_STAT_OVF]   = ovf_q;
      status[7:4]                   = sat_count4(32'(fifo_count));
   end

   assign port_out     = (port_id == ADDR_STAT) ? status : 8'h00;
   assign tx_byte      = tx_byte_q;
   assign int_tx_empty = fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table, directed corner sequences, random vs model.
module tb_uart_tx_sched;

   localparam logic [7:0] A_DATA = 8'h10;
   localparam logic [7:0] A_CTRL = 8'h11;
   localparam logic [7:0] A_STAT = 8'h12;
   localparam int         DEPTH  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] port_id, port_in, port_out, tx_byte;
   logic       wen, ren, tx_dv, tx_done, int_tx_empty;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_sched #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .port_id      (port_id),
      .port_in      (port_in),
      .wen          (wen),
      .ren          (ren),
      .port_out     (port_out),
      .tx_dv        (tx_dv),
      .tx_byte      (tx_byte),
      .tx_done      (tx_done),
      .int_tx_empty (int_tx_empty)
   );

   // Reference model: byte queue plus timestamps of the current transfer's start and done.
   logic [7:0] m_q[$];
   bit         m_en, m_ovf;
   logic [7:0] m_cur;
   int         mcyc, m_start, m_done;

   logic [7:0] s_out, s_byte;
   logic       s_dv, s_irq;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   // Busy from the start pulse until one cycle after tx_done was accepted.
   function automatic bit m_busy();
      return (m_done < m_start) || (mcyc <= m_done + 1);
   endfunction

   function automatic logic [7:0] m_status();
      int c;
      c = m_q.size();
      return {4'(c > 15 ? 15 : c), m_ovf, m_busy(), c == DEPTH, c == 0};
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_en = 0; m_ovf = 0; m_cur = 8'h00;
      mcyc = 0; m_start = -100; m_done = -50;
   endtask

   task automatic m_step(input logic w, r, input logic [7:0] id, d, input logic dn);
      bit b, full, pop, fl, wr;
      b    = m_busy();
      full = (m_q.size() == DEPTH);
      pop  = !b && m_en && (m_q.size() > 0);
      fl   = w && (id == A_CTRL) && d[1];
      wr   = w && (id == A_DATA);
      if (dn && mcyc > m_start && m_done < m_start) m_done = mcyc;
      if (pop) begin
         m_cur   = m_q.pop_front();
         m_start = mcyc + 1;
      end
      if (fl) m_q.delete();
      else if (wr && (!full || pop)) m_q.push_back(d);
      if (wr && !fl && full && !pop) m_ovf = 1;
      else if (r && id == A_STAT) m_ovf = 0;
      if (w && id == A_CTRL) m_en = d[0];
      mcyc++;
   endtask

   // One clock cycle: drive, sample mid-cycle, compare with model, advance model.
   task automatic cyc_step(input logic w, r, input logic [7:0] id, d, input logic dn);
      wen = w; ren = r; port_id = id; port_in = d; tx_done = dn;
      @(negedge clk);
      s_dv = tx_dv; s_byte = tx_byte; s_out = port_out; s_irq = int_tx_empty;
      check("model tx_dv", {7'd0, s_dv}, {7'd0, mcyc == m_start});
      check("model tx_byte", s_byte, m_cur);
      check("model port_out", s_out, (id == A_STAT) ? m_status() : 8'h00);
      check("model int_tx_empty", {7'd0, s_irq}, {7'd0, m_q.size() == 0 && !m_busy()});
      m_step(w, r, id, d, dn);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wen = 0; ren = 0; port_id = A_STAT; port_in = 8'h00; tx_done = 0;
      rst = 1'b1;
      #1;
      check("reset tx_dv", {7'd0, tx_dv}, 8'h00);
      check("reset tx_byte", tx_byte, 8'h00);
      check("reset status", port_out, 8'h01);
      check("reset int_tx_empty", {7'd0, int_tx_empty}, 8'h01);
      m_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_step(0, 0, 8'h00, 8'h00, 0);
   endtask

   typedef struct {
      logic       w;
      logic       r;
      logic [7:0] id;
      logic [7:0] d;
      logic [7:0] exp_out;
      logic       exp_irq;
   } vec_t;

   vec_t tbl[14];
   int   dv_t[4];
   logic [7:0] dv_b[4];
   int   ndv;

   initial begin
      rst = 1'b1;
      do_reset();

      // Fill with en=0, overflow, read-to-clear ovf, then flush.
      for (int i = 0; i < 8; i++) tbl[i] = '{1, 0, A_DATA, 8'(i), 8'h00, i == 0};
      tbl[8]  = '{1, 0, A_DATA, 8'hFF, 8'h00, 0};
      tbl[9]  = '{0, 1, A_STAT, 8'h00, 8'h8A, 0};
      tbl[10] = '{0, 1, A_STAT, 8'h00, 8'h82, 0};
      tbl[11] = '{0, 0, A_STAT, 8'h00, 8'h82, 0};
      tbl[12] = '{1, 0, A_CTRL, 8'h02, 8'h00, 0};
      tbl[13] = '{0, 0, A_STAT, 8'h00, 8'h01, 1};
      for (int i = 0; i < 14; i++) begin
         cyc_step(tbl[i].w, tbl[i].r, tbl[i].id, tbl[i].d, 0);
         check($sformatf("vec%0d port_out", i), s_out, tbl[i].exp_out);
         check($sformatf("vec%0d int_tx_empty", i), {7'd0, s_irq}, {7'd0, tbl[i].exp_irq});
         check($sformatf("vec%0d tx_dv", i), {7'd0, s_dv}, 8'h00);
      end

      // Single byte latency and empty interrupt after completion.
      do_reset();
      cyc_step(1, 0, A_CTRL, 8'h01, 0);
      cyc_step(1, 0, A_DATA, 8'hA5, 0);
      cyc_step(0, 0, A_STAT, 8'h00, 0);
      check("lat dv early", {7'd0, s_dv}, 8'h00);
      cyc_step(0, 0, A_STAT, 8'h00, 0);
      check("lat dv", {7'd0, s_dv}, 8'h01);
      check("lat byte", s_byte, 8'hA5);
      idle(4);
      cyc_step(0, 0, 8'h00, 8'h00, 1);
      cyc_step(0, 0, 8'h00, 8'h00, 0);
      check("gap irq", {7'd0, s_irq}, 8'h00);
      cyc_step(0, 0, 8'h00, 8'h00, 0);
      check("idle irq", {7'd0, s_irq}, 8'h01);

      // Three queued bytes, transmitter done 20 cycles after each start.
      do_reset();
      cyc_step(1, 0, A_CTRL, 8'h01, 0);
      ndv = 0;
      for (int i = 0; i < 90; i++) begin
         cyc_step(i < 3, 0, (i < 3) ? A_DATA : 8'h00, 8'h31 + 8'(i),
                  ndv > 0 && i == dv_t[ndv-1] + 20);
         if (s_dv && ndv < 4) begin
            dv_t[ndv] = i;
            dv_b[ndv] = s_byte;
            ndv++;
         end
      end
      check("b2b pulses", 8'(ndv), 8'd3);
      check("b2b gap1", 8'(dv_t[1] - dv_t[0]), 8'd23);
      check("b2b gap2", 8'(dv_t[2] - dv_t[1]), 8'd23);
      for (int k = 0; k < 3; k++) check($sformatf("b2b byte%0d", k), dv_b[k], 8'h31 + 8'(k));

      // Full FIFO: push lands in the same cycle as the pop.
      do_reset();
      for (int i = 0; i < 8; i++) cyc_step(1, 0, A_DATA, 8'h50 + 8'(i), 0);
      cyc_step(1, 0, A_CTRL, 8'h01, 0);
      cyc_step(1, 0, A_DATA, 8'h99, 0);
      cyc_step(0, 0, A_STAT, 8'h00, 0);
      check("full pop+push status", s_out, 8'h86);

      // Flush during WAIT keeps the in-flight byte, nothing follows.
      do_reset();
      cyc_step(1, 0, A_CTRL, 8'h01, 0);
      for (int i = 0; i < 5; i++) cyc_step(1, 0, A_DATA, 8'hC0 + 8'(i), 0);
      cyc_step(0, 0, A_STAT, 8'h00, 0);
      check("pre-flush status", s_out, 8'h44);
      cyc_step(1, 0, A_CTRL, 8'h02, 0);
      cyc_step(0, 0, A_STAT, 8'h00, 0);
      check("post-flush status", s_out, 8'h05);
      cyc_step(0, 0, 8'h00, 8'h00, 1);
      ndv = 0;
      for (int i = 0; i < 30; i++) begin
         cyc_step(0, 0, A_STAT, 8'h00, 0);
         if (s_dv) ndv++;
      end
      check("post-flush no dv", 8'(ndv), 8'd0);
      check("post-flush idle", s_out, 8'h01);

      // Reset during WAIT discards everything.
      do_reset();
      cyc_step(1, 0, A_CTRL, 8'h01, 0);
      for (int i = 0; i < 6; i++) cyc_step(1, 0, A_DATA, 8'hE0 + 8'(i), 0);
      cyc_step(0, 0, A_STAT, 8'h00, 0);
      check("pre-reset status", s_out, 8'h54);
      do_reset();
      cyc_step(0, 0, A_STAT, 8'h00, 0);
      check("post-reset status", s_out, 8'h01);
      cyc_step(1, 0, A_CTRL, 8'h01, 0);
      ndv = 0;
      for (int i = 0; i < 20; i++) begin
         cyc_step(0, 0, 8'h00, 8'h00, 0);
         if (s_dv) ndv++;
      end
      check("post-reset no dv", 8'(ndv), 8'd0);
      cyc_step(1, 0, A_DATA, 8'h3C, 0);
      idle(1);
      cyc_step(0, 0, 8'h00, 8'h00, 0);
      check("post-reset new dv", {7'd0, s_dv}, 8'h01);
      check("post-reset new byte", s_byte, 8'h3C);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int unsigned sel;
         logic [7:0]  id, d;
         logic        w, r, dn;
         sel = $urandom_range(0, 99);
         if (sel < 40)      id = A_DATA;
         else if (sel < 48) id = A_CTRL;
         else if (sel < 78) id = A_STAT;
         else               id = 8'($urandom);
         d = 8'($urandom);
         if (id == A_CTRL)
            d = {6'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0};
         w  = 1'($urandom_range(0, 1));
         r  = ($urandom_range(0, 2) == 0);
         dn = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else cyc_step(w, r, id, d, dn);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
